dmaapb_lock_rst_seq: RTL and testbench

//  Reset sequencer downstream of the fabric CCC. Consumes GL0 and PLL LOCK.

---
 rtl/dmaapb_rst_pkg.sv | 15 +
 rtl/dmaapb_sync2.sv | 13 +
 rtl/dmaapb_lock_rst_seq.sv | 91 +++++++++
 tb/tb_dmaapb_lock_rst_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaapb_rst_pkg.sv
// dmaapb_rst_pkg: shared state encoding, loss-counter sizing and counter-width helper
package dmaapb_rst_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;
  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_SAT = 8'd255;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b);
  endfunction
endpackage

// File: rtl/dmaapb_sync2.sv
// dmaapb_sync2: two-flop synchroniser into the GL0 domain, cleared by RESET
module dmaapb_sync2 (
  input  logic GL0,
  input  logic RESET,
  input  logic D,
  output logic Q
);
  logic meta;
  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge GL0 or posedge RESET)
    if (RESET) {Q, meta} <= 2'b00;
    else {Q, meta} <= {meta, D};
endmodule

// File: rtl/dmaapb_lock_rst_seq.sv
// dmaapb_lock_rst_seq: lock-qualified staggered reset release; optional lock-loss counter via LOCK_LOSS_CNT_EN
module dmaapb_lock_rst_seq
  import dmaapb_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int NUM_DOMAINS        = 3
) (
  input  logic                   GL0,
  input  logic                   RESET,
  input  logic                   LOCK,
  input  logic                   SW_RESET,
  output logic [NUM_DOMAINS-1:0] RST_N,
  output logic                   READY,
  output logic [STATE_W-1:0]     STATE,
  output logic [LOSS_W-1:0]      LOSS_CNT
);
  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam int IW = $clog2(NUM_DOMAINS + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_DOMAINS-1:0] rst_n_n;
  logic ready_n, lock_s;
  dmaapb_sync2 u_sync (.GL0(GL0), .RESET(RESET), .D(LOCK), .Q(lock_s));
  // state, counters and registered reset outputs
  always_ff @(posedge GL0 or posedge RESET)
    if (RESET) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      idx   <= '0;
      RST_N <= '0;
      READY <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      RST_N <= rst_n_n;
      READY <= ready_n;
    end
  // lock loss beats SW_RESET; SW_RESET only matters once releasing has begun
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rst_n_n = RST_N;
    ready_n = READY;
    if (state != WAIT_LOCK && !lock_s) begin
      state_n = WAIT_LOCK;
      cnt_n   = '0;
      rst_n_n = '0;
      ready_n = 1'b0;
    end else if ((state == RELEASE || state == RUN) && SW_RESET) begin
      state_n = STABILIZE;
      cnt_n   = '0;
      rst_n_n = '0;
      ready_n = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: if (lock_s) begin
          state_n = STABILIZE;
          cnt_n   = '0;
        end
        STABILIZE: if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          rst_n_n[0] = 1'b1;
          cnt_n      = '0;
          idx_n      = IW'(1);
          state_n    = NUM_DOMAINS == 1 ? RUN : RELEASE;
          ready_n    = NUM_DOMAINS == 1;
        end else cnt_n = cnt + CW'(1);
        RELEASE: if (cnt == CW'(STAGGER_CYCLES - 1)) begin
          rst_n_n = RST_N | (NUM_DOMAINS'(1) << idx);
          idx_n   = idx + IW'(1);
          cnt_n   = '0;
          state_n = idx == IW'(NUM_DOMAINS - 1) ? RUN : RELEASE;
          ready_n = idx == IW'(NUM_DOMAINS - 1);
        end else cnt_n = cnt + CW'(1);
        RUN: ;
      endcase
    end
  end
  assign STATE = state;
`ifdef LOCK_LOSS_CNT_EN
  // one count per lock loss: the edge that drops back to WAIT_LOCK
  always_ff @(posedge GL0 or posedge RESET)
    if (RESET) LOSS_CNT <= '0;
    else if (state != WAIT_LOCK && !lock_s && LOSS_CNT != LOSS_SAT) LOSS_CNT <= LOSS_CNT + LOSS_W'(1);
`else
  assign LOSS_CNT = '0;
`endif
endmodule

// File: tb/tb_dmaapb_lock_rst_seq.sv
// tb_dmaapb_lock_rst_seq: scoreboard-driven checks of lock qualification, staggered release, loss and resets
module tb_dmaapb_lock_rst_seq;
  logic GL0 = 1'b0, RESET = 1'b1, LOCK = 1'b0, SW_RESET = 1'b0;
  logic [2:0] RST_N;
  logic READY;
  logic [1:0] STATE;
  logic [7:0] LOSS_CNT;
  int n_cmp = 0, n_bad = 0, ec = 0, exp_loss = 0;
  typedef struct {int at; logic [2:0] rst; logic rdy; logic [1:0] st;} exp_t;
  exp_t sb[$];

  dmaapb_lock_rst_seq #(.LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .NUM_DOMAINS(3)) dut (
    .GL0(GL0), .RESET(RESET), .LOCK(LOCK), .SW_RESET(SW_RESET),
    .RST_N(RST_N), .READY(READY), .STATE(STATE), .LOSS_CNT(LOSS_CNT)
  );

  always #5 GL0 = ~GL0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge GL0);
    #1;
    ec++;
  endtask

  task automatic push(input int at, input logic [2:0] r, input logic rd, input logic [1:0] s);
    sb.push_back('{at, r, rd, s});
  endtask

  // expected outputs around each release, relative to the STABILIZE entry edge
  task automatic push_seq(input int base);
    push(base + 7, 3'b000, 1'b0, 2'd1);
    push(base + 8, 3'b001, 1'b0, 2'd2);
    push(base + 11, 3'b001, 1'b0, 2'd2);
    push(base + 12, 3'b011, 1'b0, 2'd2);
    push(base + 15, 3'b011, 1'b0, 2'd2);
    push(base + 16, 3'b111, 1'b1, 2'd3);
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (ec < e.at) tick();
      n_cmp++;
      if (RST_N !== e.rst || READY !== e.rdy || STATE !== e.st) begin
        n_bad++;
        $display("FAIL %s edge %0d: got RST_N=%b READY=%b STATE=%0d, want RST_N=%b READY=%b STATE=%0d",
                 name, ec, RST_N, READY, STATE, e.rst, e.rdy, e.st);
      end
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (STATE === st) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic bump_loss();
`ifdef LOCK_LOSS_CNT_EN
    exp_loss = exp_loss < 255 ? exp_loss + 1 : 255;
`endif
  endtask

  task automatic check_loss(input string name);
    n_cmp++;
    if (LOSS_CNT !== exp_loss[7:0]) begin
      n_bad++;
      $display("FAIL %s: LOSS_CNT got %0d want %0d", name, LOSS_CNT, exp_loss);
    end
  endtask

  task automatic relock(input string name);
    int n;
    LOCK = 1'b1;
    wait_state(2'd1, 4, n);
    n_cmp++;
    if (n < 0) begin
      n_bad++;
      $display("FAIL %s: STATE got %0d want 1 within 4 edges", name, STATE);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (RST_N !== 3'b000 || READY !== 1'b0 || STATE !== 2'd0 || LOSS_CNT !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: got RST_N=%b READY=%b STATE=%0d LOSS=%0d want 000/0/0/0", RST_N, READY, STATE, LOSS_CNT);
    end
    tick();
    tick();
    RESET = 1'b0;
    tick();
    n_cmp++;
    if (STATE !== 2'd0 || RST_N !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: got STATE=%0d RST_N=%b want 0/000", STATE, RST_N);
    end
  endtask

  task automatic test_powerup();
    int n;
    LOCK = 1'b1;
    tick();
    n_cmp++;
    if (STATE !== 2'd0) begin
      n_bad++;
      $display("FAIL powerup_sync: STATE got %0d want 0 at first edge after LOCK", STATE);
    end
    wait_state(2'd1, 2, n);
    n_cmp++;
    if (n < 0) begin
      n_bad++;
      $display("FAIL powerup_entry: STATE got %0d want 1", STATE);
    end
    push_seq(ec);
    drain("powerup");
  endtask

  task automatic test_lock_drop_run();
    LOCK = 1'b0;
    push(ec + 1, 3'b111, 1'b1, 2'd3);
    push(ec + 2, 3'b111, 1'b1, 2'd3);
    push(ec + 3, 3'b000, 1'b0, 2'd0);
    drain("drop_run");
    bump_loss();
    check_loss("drop_run_loss");
  endtask

  task automatic test_lock_drop_release();
    relock("drop_rel_relock");
    push(ec + 8, 3'b001, 1'b0, 2'd2);
    drain("drop_rel_first");
    LOCK = 1'b0;
    push(ec + 1, 3'b001, 1'b0, 2'd2);
    push(ec + 2, 3'b001, 1'b0, 2'd2);
    push(ec + 3, 3'b000, 1'b0, 2'd0);
    drain("drop_rel");
    bump_loss();
    check_loss("drop_rel_loss");
    relock("drop_rel_relock2");
    push_seq(ec);
    drain("drop_rel_repeat");
  endtask

  task automatic test_sw_reset();
    SW_RESET = 1'b1;
    tick();
    SW_RESET = 1'b0;
    n_cmp++;
    if (STATE !== 2'd1 || RST_N !== 3'b000 || READY !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_reset: got STATE=%0d RST_N=%b READY=%b want 1/000/0", STATE, RST_N, READY);
    end
    push_seq(ec);
    drain("sw_resequence");
    LOCK = 1'b0;
    tick();
    tick();
    SW_RESET = 1'b1;
    tick();
    SW_RESET = 1'b0;
    n_cmp++;
    if (STATE !== 2'd0 || RST_N !== 3'b000) begin
      n_bad++;
      $display("FAIL sw_vs_loss: got STATE=%0d RST_N=%b want 0/000", STATE, RST_N);
    end
    bump_loss();
    check_loss("sw_vs_loss_cnt");
  endtask

  task automatic test_async_reset();
    relock("async_relock");
    tick();
    tick();
    #3;
    RESET = 1'b1;
    #1;
    exp_loss = 0;
    n_cmp++;
    if (STATE !== 2'd0 || RST_N !== 3'b000 || READY !== 1'b0 || LOSS_CNT !== 8'd0) begin
      n_bad++;
      $display("FAIL async_stab: got STATE=%0d RST_N=%b READY=%b LOSS=%0d want 0/000/0/0", STATE, RST_N, READY, LOSS_CNT);
    end
    tick();
    RESET = 1'b0;
    relock("async_restart");
    push_seq(ec);
    drain("async_restart_seq");
    #3;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (STATE !== 2'd0 || RST_N !== 3'b000 || READY !== 1'b0) begin
      n_bad++;
      $display("FAIL async_run: got STATE=%0d RST_N=%b READY=%b want 0/000/0", STATE, RST_N, READY);
    end
    tick();
    RESET = 1'b0;
    relock("async_run_restart");
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 300; i++) begin
      LOCK = 1'b0;
      wait_state(2'd0, 5, n);
      bump_loss();
      n_cmp++;
      if (n < 0) begin
        n_bad++;
        $display("FAIL sat_drop iter %0d: STATE got %0d want 0", i, STATE);
      end
      relock("sat_relock");
    end
    check_loss("sat_value");
    LOCK = 1'b0;
    wait_state(2'd0, 5, n);
    check_loss("sat_hold");
    #3;
    RESET = 1'b1;
    #1;
    exp_loss = 0;
    check_loss("sat_clear");
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_drop_run();
    test_lock_drop_release();
    test_sw_reset();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
